// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
    parameter int SYS_CLK_FREQ    = 100000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [FIFO_DEPTH_LOG2:0]   count,
    output logic                       busy,
    output logic                       tx
);

    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int DEPTH        = 1 << FIFO_DEPTH_LOG2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]         BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic [7:0]                 r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   r_count;
    logic                       r_full;
    logic                       r_empty;
    state_t                     r_state;
    logic [CNT_W-1:0]           r_baud_cnt;
    logic [2:0]                 r_bit_idx;
    logic [7:0]                 r_shift;
    logic                       r_tx;
    logic                       r_busy;

    state_t                     w_state_nxt;
    logic [CNT_W-1:0]           w_baud_nxt;
    logic [2:0]                 w_bit_nxt;
    logic [2:0]                 w_bit_inc;
    logic [7:0]                 w_shift_nxt;
    logic                       w_tx_nxt;
    logic                       w_pop;
    logic                       w_wr_acc;
    logic                       w_baud_end;
    logic [FIFO_DEPTH_LOG2:0]   w_count_nxt;

    assign w_wr_acc   = wr_en & ~r_full;
    assign w_baud_end = (r_baud_cnt == BAUD_LAST);
    assign w_bit_inc  = r_bit_idx + 3'd1;

    // Next-state, line value and pop request for the serialiser FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end else begin
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_nxt    = even_parity(r_shift);
                        w_state_nxt = S_PARITY;
`else
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = w_bit_inc;
                        w_tx_nxt  = r_shift[w_bit_inc];
                    end
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_STOP;
                end else begin
                    w_state_nxt = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!r_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd_ptr];
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = S_START;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            default: begin
                w_baud_nxt  = '0;
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FIFO occupancy update from accepted writes and pops.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents are qualified by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == COUNT_FULL);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Serialiser state, counters and registered line outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;
    assign busy  = r_busy;
    assign tx    = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: line-level reference model (byte queue plus frame timer)
// compared against every DUT output on every cycle, with randomized traffic.
module tb_uart_tx_fifo;

    localparam int SYS_CLK_FREQ = 1000;
    localparam int BAUD_RATE    = 100;
    localparam int LOG2         = 4;
    localparam int CPB          = SYS_CLK_FREQ / BAUD_RATE;
    localparam int DEPTH        = 1 << LOG2;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr_en = 1'b0;
    logic [7:0]      wr_data = 8'd0;
    logic            full, empty, busy, tx;
    logic [LOG2:0]   count;
    logic [8:0]      dut_vec;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .SYS_CLK_FREQ   (SYS_CLK_FREQ),
        .BAUD_RATE      (BAUD_RATE),
        .FIFO_DEPTH_LOG2(LOG2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .full   (full),
        .empty  (empty),
        .count  (count),
        .busy   (busy),
        .tx     (tx)
    );

    assign dut_vec = {tx, busy, full, empty, count};

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: queued bytes, plus the frame on the wire and its start edge.
    logic [7:0] q[$];
    bit         m_active = 1'b0;
    int         m_start  = 0;
    logic [7:0] m_byte   = 8'd0;
    int         n        = 0;

    function automatic logic model_tx();
        int k;
        if (!m_active) return 1'b1;
        k = (n - m_start) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^m_byte;
`endif
        return 1'b1;
    endfunction

    function automatic logic [8:0] model_vec();
        logic [4:0] c;
        c = 5'(q.size());
        return {model_tx(), m_active, (q.size() == DEPTH), (q.size() == 0), c};
    endfunction

    function automatic bit model_idle();
        return !m_active && (q.size() == 0);
    endfunction

    task automatic tick(input logic we, input logic [7:0] d);
        bit pop;
        bit frame_end;
        bit acc;
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        n++;
        pop       = 1'b0;
        frame_end = 1'b0;
        if (!m_active) begin
            pop = (q.size() != 0);
        end else if (n - m_start == FRAME) begin
            frame_end = 1'b1;
            pop       = (q.size() != 0);
        end
        acc = we && (q.size() < DEPTH);
        if (pop) begin
            m_byte   = q.pop_front();
            m_active = 1'b1;
            m_start  = n;
        end else if (frame_end) begin
            m_active = 1'b0;
        end
        if (acc) q.push_back(d);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_active = 1'b0;
        n        = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (dut_vec !== 9'b1_0_0_1_00000) begin
            n_fail++;
            $display("FAIL reset_state got %b want %b", dut_vec, 9'b1_0_0_1_00000);
        end
    endtask

    task automatic test_single_byte();
        int busy_cyc = 0;
        int i;
        tick(1'b1, 8'hA5);
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL single_write cyc=%0d got %b want %b", n, dut_vec, model_vec());
        end
        for (i = 0; i < FRAME + 20; i++) begin
            tick(1'b0, 8'h00);
            if (busy) busy_cyc++;
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL single_frame cyc=%0d got %b want %b", n, dut_vec, model_vec());
            end
        end
        n_cmp++;
        if (busy_cyc !== FRAME) begin
            n_fail++;
            $display("FAIL single_busy_len got %0d want %0d", busy_cyc, FRAME);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic [4:0] exp_cnt [3];
        int busy_cyc = 0;
        int gaps = 0;
        bit seen_busy = 1'b0;
        int i;
        bytes   = '{8'h00, 8'hFF, 8'h55};
        exp_cnt = '{5'd1, 5'd1, 5'd2};
        for (int j = 0; j < 3; j++) begin
            tick(1'b1, bytes[j]);
            if (busy) begin busy_cyc++; seen_busy = 1'b1; end
            n_cmp++;
            if (count !== exp_cnt[j] || dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL b2b_write%0d count got %0d want %0d vec got %b want %b",
                         j, count, exp_cnt[j], dut_vec, model_vec());
            end
        end
        for (i = 0; i < 4 * FRAME && !model_idle(); i++) begin
            tick(1'b0, 8'h00);
            if (busy) begin busy_cyc++; seen_busy = 1'b1; end
            else if (seen_busy && !model_idle()) gaps++;
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL b2b_frame cyc=%0d got %b want %b", n, dut_vec, model_vec());
            end
        end
        n_cmp++;
        if (busy_cyc !== 3 * FRAME || gaps !== 0) begin
            n_fail++;
            $display("FAIL b2b_total busy got %0d want %0d gaps got %0d want 0",
                     busy_cyc, 3 * FRAME, gaps);
        end
    endtask

    task automatic test_full_overflow();
        int i;
        for (int j = 0; j < 17; j++) begin
            tick(1'b1, 8'(j));
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL full_fill%0d got %b want %b", j, dut_vec, model_vec());
            end
        end
        n_cmp++;
        if (full !== 1'b1 || count !== 5'd16) begin
            n_fail++;
            $display("FAIL full_flag full got %b want 1 count got %0d want 16", full, count);
        end
        tick(1'b1, 8'h11);
        n_cmp++;
        if (count !== 5'd16 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL full_drop count got %0d want 16 vec got %b want %b",
                     count, dut_vec, model_vec());
        end
        for (i = 0; i < 18 * FRAME && !model_idle(); i++) begin
            tick(1'b0, 8'h00);
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL full_drain cyc=%0d got %b want %b", n, dut_vec, model_vec());
            end
        end
        n_cmp++;
        if (!model_idle() || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain_timeout busy got %b want 0", busy);
        end
    endtask

    task automatic test_pop_and_write();
        int i;
        tick(1'b1, 8'h81);
        tick(1'b1, 8'h42);
        for (i = 0; i < 2 * FRAME && (n + 1 - m_start) != FRAME; i++) begin
            tick(1'b0, 8'h00);
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL simul_wait cyc=%0d got %b want %b", n, dut_vec, model_vec());
            end
        end
        tick(1'b1, 8'h99);
        n_cmp++;
        if (count !== 5'd1 || busy !== 1'b1 || tx !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_edge count got %0d want 1 busy got %b want 1 tx got %b want 0",
                     count, busy, tx);
        end
        for (i = 0; i < 3 * FRAME && !model_idle(); i++) begin
            tick(1'b0, 8'h00);
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL simul_drain cyc=%0d got %b want %b", n, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_reset_midframe();
        int i;
        tick(1'b1, 8'h3C);
        for (i = 0; i < 2 * FRAME && !(m_active && (n - m_start) == 4 * CPB + 4); i++) begin
            tick(1'b0, 8'h00);
        end
        n_cmp++;
        if (tx !== model_tx() || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_pre tx got %b want %b busy got %b want 1",
                     tx, model_tx(), busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_reset tx=%b busy=%b count=%0d empty=%b want 1 0 0 1",
                     tx, busy, count, empty);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_active = 1'b0;
        n        = 0;
        for (i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0, 8'h00);
            n_cmp++;
            if (tx !== 1'b1 || dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL midframe_after cyc=%0d got %b want %b", n, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_random();
        int i;
        for (i = 0; i < 2500; i++) begin
            tick(($urandom_range(0, 99) < 9), 8'($urandom));
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got %b want %b", n, dut_vec, model_vec());
            end
        end
        for (i = 0; i < 18 * FRAME && !model_idle(); i++) begin
            tick(1'b0, 8'h00);
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random_drain cyc=%0d got %b want %b", n, dut_vec, model_vec());
            end
        end
        n_cmp++;
        if (!model_idle() || busy !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL random_timeout busy got %b want 0 empty got %b want 1", busy, empty);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_full_overflow();
        test_pop_and_write();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: the transmit-side counterpart of the SoC's `Rx` serial input.
- Accepts bytes over a single-cycle write strobe into an internal FIFO.
- Serialises the bytes as 8N1 frames, LSB first, on `tx`.
- Used as the SoC's `Tx` path, and in simulation as the host-side driver that feeds the CPU's `Rx` pin.

Parameters:
- SYS_CLK_FREQ, 100000000: `clk` frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. CLKS_PER_BIT = SYS_CLK_FREQ/BAUD_RATE, integer-truncated, must be >= 2.
- FIFO_DEPTH_LOG2, 4: FIFO holds 2^FIFO_DEPTH_LOG2 bytes.

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe; accepted only when full=0
- wr_data  in  8  byte to enqueue
- full  out  1  FIFO holds 2^FIFO_DEPTH_LOG2 bytes
- empty  out  1  FIFO holds 0 bytes
- count  out  FIFO_DEPTH_LOG2+1  FIFO occupancy; excludes the byte currently being shifted
- busy  out  1  FSM is not in IDLE
- tx  out  1  serial line; idle high

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - tx=1, busy=0, empty=1, full=0, count=0.
  - FIFO pointers cleared; FSM to IDLE; baud counter and bit index cleared.
  - Any frame in flight is abandoned.
- FIFO:
  - Circular buffer with wrapping read and write pointers; count is a registered counter.
  - Write accepted on an edge with wr_en=1 and full=0: data stored, write pointer advances.
  - wr_en=1 with full=1: byte dropped; no state change, even if a pop occurs on the same edge.
  - Simultaneous accepted write and pop: count unchanged; both pointers advance.
  - Pointers wrap from 2^FIFO_DEPTH_LOG2-1 to 0.
- FSM states: IDLE, START, DATA, STOP. The baud counter counts 0..CLKS_PER_BIT-1.
  - IDLE: tx=1. If empty=0 at an edge: pop the head byte into the shift register, tx<=0, go to START, counter<=0.
  - Consequence: a write to an empty idle block makes tx go low 1 cycle after the write edge.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then tx<=data[0], bit index<=0, go to DATA.
  - DATA: each bit held CLKS_PER_BIT cycles, LSB first. After bit 7 completes: tx<=1, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end:
    - FIFO non-empty: pop and enter START in the same edge (back-to-back frames, no idle gap).
    - FIFO empty: go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- busy is 1 in START, DATA and STOP; it is a registered output.
- tx is a registered output and never glitches.
- count never exceeds 2^FIFO_DEPTH_LOG2.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - The parity bit is even parity (XOR of the 8 data bits), held for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT.
- Undefined: 8N1 exactly as above; no PARITY state is synthesised.

Test Plan:
- Use SYS_CLK_FREQ=1000 and BAUD_RATE=100, so CLKS_PER_BIT=10.
- Single byte:
  - Stimulus: rst pulse, then write 0xA5 once.
  - Required: tx low 1 cycle after the write edge for 10 cycles.
  - Data bits 1,0,1,0,0,1,0,1, each 10 cycles, then stop bit high.
  - busy=1 for exactly 100 cycles, then busy=0 and empty=1.
- Back-to-back:
  - Stimulus: write 0x00, 0xFF, 0x55 on consecutive cycles.
  - Required: three frames with no idle gap between them, 300 cycles in total.
  - count sequence: 1, 1, 2 on the three write edges (the first byte is popped immediately), then decrementing as frames start.
- Full/overflow:
  - Stimulus: 17 consecutive writes of 0x00..0x10, with FIFO_DEPTH_LOG2=4 and the first byte popped.
  - Required: full=1 after the 17th write; an 18th write of 0x11 is dropped.
  - Received stream is 0x00..0x10 in order.
- Reset mid-frame:
  - Stimulus: write 0x3C, assert rst during data bit 3.
  - Required: tx=1, busy=0, count=0 in the same cycle.
  - After release, tx stays 1 with no resumed frame.
- Parity build (UART_TX_PARITY_EN defined):
  - Stimulus: write 0x07.
  - Required: parity bit = 1; frame is 110 cycles.
- Simultaneous pop and write at count=1:
  - Stimulus: a write lands on the STOP-end pop edge.
  - Required: count stays 1; pointers advance; order is preserved.
